dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and access sequencer in front of the single-port data memory (256 x 32-bit, word-addressed). It gives both the CPU load/store unit (port 0) and the loader/debug DMA engine (port 1) fair round-robin access through a valid/ready request handshake. It drives the memory's `mem_write`/`address`/`write_data` inputs for one access cycle, captures `read_data`, and returns a one-cycle response with an error flag for bad addresses.

## Interface
- `DATA_W`, default 32: data width of requests, responses and memory.
- `ADDR_W`, default 32: byte-address width.
- `DEPTH_WORDS`, default 256: memory depth in words, used for the range check.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `req_valid` input 2: per-port request valid, bit i = port i.
- `req_ready` output 2: per-port grant/accept; the handshake completes when `req_valid[i] && req_ready[i]`.
- `req_write` input 2: per-port write (1) or read (0).
- `req_addr` input 2 x ADDR_W: per-port byte address, packed, port i in slice i.
- `req_wdata` input 2 x DATA_W: per-port write data.
- `rsp_valid` output 2: one-cycle response pulse to the owning port.
- `rsp_rdata` output DATA_W: read data, shared, qualified by `rsp_valid`.
- `rsp_err` output 1: error flag, shared, qualified by `rsp_valid`.
- `busy` output 1: high while in ACCESS.
- `mem_write` output 1: to memory write enable.
- `address` output ADDR_W: to memory address.
- `write_data` output DATA_W: to memory write data.
- `read_data` input DATA_W: from memory, combinational read.

## Operation
- **FSM states:** IDLE and ACCESS.
- **IDLE:**
  - Arbitration is combinational, and `req_ready` asserts only to the granted port, and only if that port's `req_valid` is high.
  - If exactly one port is valid, that port is granted.
  - If both are valid, the port other than `last_grant` is granted (round-robin).
  - On a handshake, register the command (`owner`, `write`, `addr`, `wdata`), update `last_grant` to `owner`, and go to ACCESS.
- **ACCESS:**
  - `req_ready` is 0 for both ports.
  - `address` and `write_data` are driven from the registered command.
  - `mem_write` = `cmd_write && cmd_ok`, where `cmd_ok` = (`addr[1:0]==0`) && (`addr[ADDR_W-1:2] < DEPTH_WORDS`).
  - At the end of the cycle, load `rsp_rdata` with `read_data` for a legal read. Load 0 for a write or an error.
  - At the same edge, load `rsp_err` = !`cmd_ok`, set `rsp_valid[owner]`, and go to IDLE unconditionally.
- **Errors:** an erroneous request is never written to memory and still gets exactly one response.
- **`rsp_valid`:** high for exactly one cycle. It may coincide with the next IDLE handshake.
- **Requester rule:** a requester holds `valid`, `write`, `addr` and `wdata` stable until it is accepted. Dropping `valid` before acceptance withdraws the request with no side effect.
- **`mem_write` outside ACCESS:** 0. `address` and `write_data` keep their last registered values.

## Timing
- Handshake in cycle n → memory access (`mem_write` high for a legal write) in cycle n+1 → `rsp_valid` in cycle n+2.
- Throughput: one access per 2 cycles. The next handshake can occur in cycle n+2.
- Reset values:
  - `state` = IDLE.
  - `last_grant` = 1, so port 0 wins the first tie.
  - `req_ready` = 0 while `reset` is high.
  - `mem_write` = 0, `address` = 0, `write_data` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `busy` = 0.
- Reset asserted during ACCESS: `mem_write` drops asynchronously, no write commits at the next edge, and no response is emitted.
- One port continuously valid while the other is idle: that port is granted every IDLE cycle, so no bubble is added beyond the 2-cycle rhythm.

## Structure
- Package `dmem_pkg` holds:
  - `DEPTH_WORDS`.
  - The state enum (`ST_IDLE`, `ST_ACCESS`).
  - A 1-bit `port_id_t`.
  - The address-check function `addr_ok`.
- Sub-module `rr_arbiter2`: combinational two-way round-robin picker. Inputs are `valid[1:0]` and `last_grant`; outputs are a one-hot `grant[1:0]` and `grant_id`.
- The top level holds the FSM, command registers, range check and response registers.

## Test plan
- **Basic write/read:** reset, then port 0 writes 0xDEADBEEF to 0x10.
  - Expect cycle n+1 `mem_write`=1, `address`=0x10, `write_data`=0xDEADBEEF.
  - Expect cycle n+2 `rsp_valid`=2'b01, `rsp_err`=0.
  - Port 1 then reads 0x10: expect `rsp_valid`=2'b10, `rsp_rdata`=0xDEADBEEF.
- **Tie fairness:** both ports hold `valid` for 4 requests. Expect grants in order 0,1,0,1, each response routed to the correct `rsp_valid` bit.
- **Address errors:**
  - Write to 0x400: `mem_write` stays 0, `rsp_err`=1, `rsp_rdata`=0.
  - Read from 0x13 (misaligned): `rsp_err`=1, `rsp_rdata`=0.
  - A following read of 0x0 returns the prior memory value.
- **Back-to-back:** port 0 keeps `valid` high through ACCESS. Expect `req_ready`=0 in ACCESS, and the next handshake in the same cycle as the previous `rsp_valid`.
- **Reset mid-access:** assert `reset` mid-cycle in ACCESS of a write of 0x12345678 to 0x20.
  - Expect `mem_write`=0 immediately and no `rsp_valid`.
  - A later read of 0x20 returns 0.
  - After release, a simultaneous request from both ports grants port 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, depth constant and address check for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int unsigned DEPTH_WORDS = 256;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef logic port_id_t;

    // Word-aligned and inside the memory; callers zero-extend their address.
    function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth_words);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(depth_words));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic [1:0] valid,
    input  port_id_t   last_grant,
    output logic [1:0] grant,
    output port_id_t   grant_id
);

    always_comb begin
        grant_id = 1'b0;
        case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
        grant = (valid == 2'b00) ? 2'b00 : (grant_id ? 2'b10 : 2'b01);
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter and access sequencer for data memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = dmem_pkg::DEPTH_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   write_data,
    input  logic [DATA_W-1:0]   read_data
);

    state_t              r_state;
    port_id_t            r_last_grant;
    port_id_t            r_cmd_owner;
    logic                r_cmd_write;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [DATA_W-1:0]   r_cmd_wdata;
    logic [1:0]          r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic [1:0]          w_grant;
    port_id_t            w_grant_id;
    logic                w_handshake;
    logic                w_cmd_ok;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_write;

    rr_arbiter2 u_rr (
        .valid      (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_id   (w_grant_id)
    );

    // Gating on reset keeps the handshake closed while reset is held.
    assign req_ready   = (!reset && r_state == ST_IDLE) ? (w_grant & req_valid) : 2'b00;
    assign w_handshake = |req_ready;

    assign w_sel_addr  = w_grant_id ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign w_sel_wdata = w_grant_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    assign w_sel_write = w_grant_id ? req_write[1] : req_write[0];

    assign w_cmd_ok    = addr_ok(64'(r_cmd_addr), DEPTH_WORDS);

    // Decoded from state so an asynchronous reset drops the write strobe at once.
    assign mem_write   = (r_state == ST_ACCESS) && r_cmd_write && w_cmd_ok;
    assign address     = r_cmd_addr;
    assign write_data  = r_cmd_wdata;
    assign busy        = (r_state == ST_ACCESS);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_cmd_owner  <= 1'b0;
            r_cmd_write  <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rsp_valid <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_handshake) begin
                        r_cmd_owner  <= w_grant_id;
                        r_cmd_write  <= w_sel_write;
                        r_cmd_addr   <= w_sel_addr;
                        r_cmd_wdata  <= w_sel_wdata;
                        r_last_grant <= w_grant_id;
                        r_state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_rsp_rdata <= (!r_cmd_write && w_cmd_ok) ? read_data : '0;
                    r_rsp_err   <= !w_cmd_ok;
                    r_rsp_valid <= r_cmd_owner ? 2'b10 : 2'b01;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_write = 2'b00;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    // The memory the arbiter fronts.
    logic [31:0] mem [256] = '{default: 32'h0};
    assign read_data = mem[address[9:2]];
    always @(posedge clk) if (mem_write) mem[address[9:2]] <= write_data;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: pending requests, one command in flight, expected memory.
    bit          pend [2];
    bit          pw   [2];
    logic [31:0] pa   [2];
    logic [31:0] pd   [2];
    bit          in_acc;
    int          cmd_p;
    bit          cmd_w;
    logic [31:0] cmd_a, cmd_d;
    logic [31:0] last_a, last_d;
    int          last_g;
    bit          rsp_due;
    logic [1:0]  exp_rv;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          rand_on;
    logic [31:0] ref_mem [256];
    int          dut_g [$];

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'h400);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return 32'h400 + 32'($urandom_range(0, 64)) * 4;
            1:       return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            default: return 32'($urandom_range(0, 15)) * 4;
        endcase
    endfunction

    task automatic post(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
        pend[p] = 1'b1; pw[p] = w; pa[p] = a; pd[p] = d;
    endtask

    task automatic model_reset();
        pend[0] = 0; pend[1] = 0; in_acc = 0; rsp_due = 0;
        last_g = 1; last_a = '0; last_d = '0;
    endtask

    // One clock of stimulus and checking; entered and left at posedge+1.
    task automatic cycle();
        logic [1:0] exp_ready;
        int         id;
        bit         ok;
        if (rsp_due) begin
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("rsp_err",   rsp_err,   exp_err);
            chk("rsp_rdata", rsp_rdata, exp_rd);
        end else begin
            chk("rsp_quiet", rsp_valid, 2'b00);
        end
        rsp_due = 0;
        if (rand_on)
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 1) == 1)
                    post(p, $urandom_range(0, 1) == 1, rand_addr(), $urandom());
        req_valid = {pend[1], pend[0]};
        req_write = {pw[1], pw[0]};
        req_addr  = {pa[1], pa[0]};
        req_wdata = {pd[1], pd[0]};
        #1;
        exp_ready = 2'b00;
        id = 0;
        if (!in_acc) begin
            if (pend[0] && pend[1]) id = 1 - last_g;
            else if (pend[1])       id = 1;
            if (pend[id]) exp_ready = 2'b01 << id;
        end
        chk("req_ready",  req_ready,  exp_ready);
        chk("busy",       busy,       in_acc);
        chk("mem_write",  mem_write,  in_acc && cmd_w && legal(cmd_a));
        chk("address",    address,    last_a);
        chk("write_data", write_data, last_d);
        if (req_ready == 2'b01) dut_g.push_back(0);
        else if (req_ready == 2'b10) dut_g.push_back(1);
        if (in_acc) begin
            ok      = legal(cmd_a);
            rsp_due = 1;
            exp_rv  = 2'b01 << cmd_p;
            exp_err = !ok;
            exp_rd  = (cmd_w || !ok) ? 32'h0 : ref_mem[cmd_a[9:2]];
            if (cmd_w && ok) ref_mem[cmd_a[9:2]] = cmd_d;
            in_acc  = 0;
        end else if (exp_ready != 2'b00) begin
            cmd_p = id; cmd_w = pw[id]; cmd_a = pa[id]; cmd_d = pd[id];
            last_a = pa[id]; last_d = pd[id];
            last_g = id; pend[id] = 0; in_acc = 1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        model_reset();
        rand_on = 0;

        // Reset: ready stays low even with both ports requesting.
        #1 reset = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rst_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        chk("rst_ready2",  req_ready,  2'b00);
        chk("rst_rsp",     rsp_valid,  2'b00);
        chk("rst_rdata",   rsp_rdata,  32'h0);
        chk("rst_err",     rsp_err,    1'b0);
        chk("rst_busy",    busy,       1'b0);
        chk("rst_mw",      mem_write,  1'b0);
        chk("rst_addr",    address,    32'h0);
        chk("rst_wdata",   write_data, 32'h0);
        reset = 1'b0;
        req_valid = 2'b00;

        // Basic write then read from the other port.
        post(0, 1, 32'h10, 32'hDEADBEEF);
        cycle(); cycle();
        chk("basic_wr_rsp", rsp_valid, 2'b01);
        post(1, 0, 32'h10, 32'h0);
        cycle(); cycle();
        chk("basic_rd_rsp",   rsp_valid, 2'b10);
        chk("basic_rd_rdata", rsp_rdata, 32'hDEADBEEF);

        // Tie fairness: both ports keep requesting.
        base = dut_g.size();
        for (int k = 0; k < 4; k++) begin
            if (!pend[0]) post(0, 1, 32'h0, 32'hCAFE0000 + 32'(k));
            if (!pend[1]) post(1, 0, 32'h10, 32'h0);
            cycle(); cycle();
        end
        pend[0] = 0;
        cycle();
        chk("tie_g0", dut_g[base],     0);
        chk("tie_g1", dut_g[base + 1], 1);
        chk("tie_g2", dut_g[base + 2], 0);
        chk("tie_g3", dut_g[base + 3], 1);

        // Address errors, then a legal read sees untouched memory.
        post(0, 1, 32'h400, 32'h55555555);
        cycle(); cycle();
        chk("err_wr_err",   rsp_err,   1'b1);
        chk("err_wr_rdata", rsp_rdata, 32'h0);
        post(1, 0, 32'h13, 32'h0);
        cycle(); cycle();
        chk("err_rd_err",   rsp_err,   1'b1);
        chk("err_rd_rdata", rsp_rdata, 32'h0);
        post(0, 0, 32'h0, 32'h0);
        cycle(); cycle();
        chk("after_err_rdata", rsp_rdata, 32'hCAFE0001);

        // Back-to-back: port 0 re-requests during ACCESS.
        base = dut_g.size();
        post(0, 1, 32'h8, 32'h11112222);
        cycle();
        post(0, 0, 32'h8, 32'h0);
        cycle();
        cycle();
        cycle(); cycle();
        chk("b2b_count", dut_g.size() - base, 2);
        chk("b2b_rdata", rsp_rdata, 32'h11112222);

        // Reset in the middle of a write access.
        post(0, 1, 32'h20, 32'h12345678);
        cycle();
        chk("mid_mw_before", mem_write, 1'b1);
        req_valid = 2'b11;
        #3 reset = 1'b1;
        #1;
        chk("mid_mw_drop", mem_write, 1'b0);
        chk("mid_busy",    busy,      1'b0);
        chk("mid_ready",   req_ready, 2'b00);
        @(posedge clk); #1;
        chk("mid_no_rsp",  rsp_valid, 2'b00);
        chk("mid_addr",    address,   32'h0);
        reset = 1'b0;
        req_valid = 2'b00;
        model_reset();
        base = dut_g.size();
        post(0, 0, 32'h20, 32'h0);
        post(1, 0, 32'h20, 32'h0);
        cycle(); cycle();
        chk("mid_rd_rsp",   rsp_valid, 2'b01);
        chk("mid_rd_rdata", rsp_rdata, 32'h0);
        cycle(); cycle(); cycle();
        chk("mid_first_grant", dut_g[base], 0);

        // Randomized traffic against the model.
        rand_on = 1;
        repeat (400) cycle();
        rand_on = 0;
        pend[0] = 0; pend[1] = 0;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
